// File: rtl/shift_step_sequencer.sv
// Multi-cycle logical shifter: iterates a shift-by-STEP stage and a shift-by-1 stage
// over several cycles to realise arbitrary shift distances behind valid/ready handshakes.
module shift_step_sequencer #(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 3,
  localparam int unsigned AW  = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [AW-1:0] in_amt,
  input  logic          in_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] AMT_MAX  = AW'(N);
  localparam logic [AW-1:0] AMT_STEP = AW'(STEP);
  localparam logic [AW-1:0] AMT_ONE  = AW'(1);

  logic [1:0]    r_state, w_state;
  logic [N-1:0]  r_data,  w_data;
  logic [AW-1:0] r_cnt,   w_cnt;
  logic          r_dir,   w_dir;
  logic [N-1:0]  r_out,   w_out;

  logic [AW-1:0] w_amt;
  logic          w_big;
  logic [N-1:0]  w_shift;
  logic [AW-1:0] w_cnt_dec;

  // Amounts above N clamp to N, which shifts every bit out and yields zero.
  assign w_amt = (in_amt > AMT_MAX) ? AMT_MAX : in_amt;

  assign w_big     = (r_cnt >= AMT_STEP);
  assign w_shift   = w_big ? (r_dir ? (r_data >> STEP) : (r_data << STEP))
                           : (r_dir ? (r_data >> 1)    : (r_data << 1));
  assign w_cnt_dec = r_cnt - (w_big ? AMT_STEP : AMT_ONE);

  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_cnt   = r_cnt;
    w_dir   = r_dir;
    w_out   = r_out;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_data = in_data;
          w_dir  = in_dir;
          w_cnt  = w_amt;
          if (w_amt == '0) begin
            w_state = S_DONE;
            w_out   = in_data;
          end else begin
            w_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_data = w_shift;
        w_cnt  = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          w_state = S_DONE;
          w_out   = w_shift;
        end
      end
      S_DONE: begin
        if (out_ready) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_cnt   <= w_cnt;
      r_dir   <= w_dir;
      r_out   <= w_out;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out;

endmodule

// File: tb/tb_shift_step_sequencer.sv
// Directed-vector and random bench for shift_step_sequencer (N=8, STEP=3).
module tb_shift_step_sequencer;

  localparam int N    = 8;
  localparam int STEP = 3;
  localparam int AW   = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_dir = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic          busy;

  int n_vec  = 0;
  int n_fail = 0;

  shift_step_sequencer #(.N(N), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  data;
    logic [AW-1:0] amt;
    logic          dir;
    logic [N-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, issues one request, returns edges from accept to out_valid.
  task automatic send(input logic [N-1:0] d, input logic [AW-1:0] a, input logic dir,
                      output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    tick();
    in_valid = 1'b0;
    in_data  = N'($urandom);
    in_dir   = ~dir;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop(input int stall, input logic [N-1:0] exp);
    for (int k = 0; k < stall; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== exp) check("stall_hold", int'(out_data), int'(exp));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic int model_lat(input int a);
    int c;
    c = (a > N) ? N : a;
    return (c / STEP) + (c % STEP) + 1;
  endfunction

  initial begin
    int lat;
    logic [N-1:0]  d;
    logic [AW-1:0] a;
    logic          dir;
    logic [N-1:0]  exp;

    vecs[0]  = '{8'hB7, 4'd3,  1'b0, 8'hB8, 2};
    vecs[1]  = '{8'hB7, 4'd3,  1'b1, 8'h16, 2};
    vecs[2]  = '{8'hFF, 4'd5,  1'b0, 8'hE0, 4};
    vecs[3]  = '{8'hFF, 4'd5,  1'b1, 8'h07, 4};
    vecs[4]  = '{8'hA5, 4'd0,  1'b0, 8'hA5, 1};
    vecs[5]  = '{8'hA5, 4'd12, 1'b0, 8'h00, 5};
    vecs[6]  = '{8'hA5, 4'd8,  1'b1, 8'h00, 5};
    vecs[7]  = '{8'h3C, 4'd1,  1'b0, 8'h78, 2};
    vecs[8]  = '{8'h81, 4'd7,  1'b1, 8'h01, 4};
    vecs[9]  = '{8'h81, 4'd6,  1'b0, 8'h40, 3};
    vecs[10] = '{8'h0F, 4'd2,  1'b0, 8'h3C, 3};
    vecs[11] = '{8'hF0, 4'd4,  1'b1, 8'h0F, 3};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].amt, vecs[i].dir, lat);
      check($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      pop(0, vecs[i].exp_data);
      check($sformatf("vec%0d_held", i), int'(out_data), int'(vecs[i].exp_data));
    end

    // Backpressure with a competing request held on the input
    send(8'hFF, 4'd5, 1'b0, lat);
    check("bp_lat", lat, 4);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    in_amt   = 4'd1;
    in_dir   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 8'hE0);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", int'(in_ready), 1);
    check("bp_idle_valid", int'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", int'(busy), 1);
    check("bp_accept_ready", int'(in_ready), 0);
    tick();
    check("bp_second_valid", int'(out_valid), 1);
    check("bp_second_data", int'(out_data), 8'h78);
    pop(0, 8'h78);

    // Reset during the second BUSY cycle of an amt=5 request
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_amt   = 4'd5;
    in_dir   = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("rstmid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_valid", int'(out_valid), 0);
    check("rstmid_ready", int'(in_ready), 1);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_data", int'(out_data), 0);
    send(8'hFF, 4'd5, 1'b1, lat);
    check("rstmid_fresh_data", int'(out_data), 8'h07);
    check("rstmid_fresh_lat", lat, 4);
    pop(0, 8'h07);

    // Random requests against the shift model
    for (int r = 0; r < 200; r++) begin
      d   = N'($urandom);
      a   = AW'($urandom_range(0, 15));
      dir = 1'($urandom);
      exp = dir ? (d >> a) : (d << a);
      send(d, a, dir, lat);
      check($sformatf("rnd%0d_data", r), int'(out_data), int'(exp));
      check($sformatf("rnd%0d_lat", r), lat, model_lat(int'(a)));
      pop($urandom_range(0, 3), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
